// File: rtl/series_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : series_accumulator
// Purpose  : Evaluates sum c_k * x^k over a term-counter stream, saturating
//            signed fixed point, with done/result_valid handshakes.
// Revision : 1.0
// ============================================================================
module series_accumulator #(
    parameter int CNTR_DEPTH = 5,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 12,
    parameter int NUM_TERMS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     x_in,
    output logic                  start_cntr,
    input  logic                  coeff_rd_en,
    input  logic [CNTR_DEPTH-1:0] term_cnt,
    output logic [CNTR_DEPTH-1:0] coeff_addr,
    input  logic [DATA_W-1:0]     coeff_data,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  ovf,
    output logic                  seq_err
);

    localparam int W2 = 2 * DATA_W;
    localparam logic signed [W2-1:0] C_SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [W2-1:0] C_SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]     C_ONE     = DATA_W'(2 ** FRAC_W);
    localparam logic [CNTR_DEPTH-1:0] C_NTERMS  = CNTR_DEPTH'(NUM_TERMS);
    localparam logic [CNTR_DEPTH-1:0] C_LAST    = CNTR_DEPTH'(NUM_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic signed [W2-1:0] sext(input logic [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

    function automatic logic clips(input logic signed [W2-1:0] v);
        return (v > C_SAT_MAX) || (v < C_SAT_MIN);
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic signed [W2-1:0] v);
        if (v > C_SAT_MAX)
            return C_SAT_MAX[DATA_W-1:0];
        else if (v < C_SAT_MIN)
            return C_SAT_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_W-1:0]     r_x;
    logic [DATA_W-1:0]     r_acc;
    logic [DATA_W-1:0]     r_pow;
    logic [CNTR_DEPTH-1:0] r_exp_k;
    logic                  r_stage_valid;
    logic                  r_done;
    logic [DATA_W-1:0]     r_result;
    logic                  r_ovf;
    logic                  r_seq_err;

    logic                  w_start_acc;
    logic                  w_accept;
    logic signed [W2-1:0]  w_prod_full;
    logic signed [W2-1:0]  w_prod_shift;
    logic signed [W2-1:0]  w_sum;
    logic signed [W2-1:0]  w_pow_full;
    logic signed [W2-1:0]  w_pow_shift;
    logic [DATA_W-1:0]     w_prod;
    logic [DATA_W-1:0]     w_acc_next;
    logic [DATA_W-1:0]     w_pow_next;
    logic                  w_mac_ovf;

    assign coeff_addr = term_cnt;
    assign done       = r_done;
    assign result     = r_result;
    assign ovf        = r_ovf;
    assign seq_err    = r_seq_err;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_accept    = (r_state == S_RUN) && coeff_rd_en && (r_exp_k < C_NTERMS);

    // Products are formed at double width so the >>> truncates toward -inf
    // before any clamping is applied.
    assign w_prod_full  = sext(coeff_data) * sext(r_pow);
    assign w_prod_shift = w_prod_full >>> FRAC_W;
    assign w_prod       = clamp(w_prod_shift);
    assign w_sum        = sext(r_acc) + sext(w_prod);
    assign w_acc_next   = clamp(w_sum);
    assign w_pow_full   = sext(r_pow) * sext(r_x);
    assign w_pow_shift  = w_pow_full >>> FRAC_W;
    assign w_pow_next   = clamp(w_pow_shift);
    assign w_mac_ovf    = clips(w_prod_shift) | clips(w_sum) | clips(w_pow_shift);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        start_cntr   = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_next = S_ARM;
            end
            S_ARM: begin
                start_cntr   = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (r_done)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                result_valid = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_acc         <= '0;
            r_pow         <= C_ONE;
            r_exp_k       <= '0;
            r_stage_valid <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_ovf         <= 1'b0;
            r_seq_err     <= 1'b0;
        end else if (w_start_acc) begin
            r_x           <= x_in;
            r_acc         <= '0;
            r_pow         <= C_ONE;
            r_exp_k       <= '0;
            r_stage_valid <= 1'b0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_stage_valid <= w_accept;
            r_done        <= w_accept && (r_exp_k == C_LAST);
            if (w_accept) begin
                r_exp_k <= r_exp_k + CNTR_DEPTH'(1);
                if (term_cnt != r_exp_k)
                    r_seq_err <= 1'b1;
            end
            if (r_stage_valid) begin
                r_acc <= w_acc_next;
                r_pow <= w_pow_next;
                if (w_mac_ovf)
                    r_ovf <= 1'b1;
            end
            // The final MAC lands on the same edge, so capture its value directly.
            if ((r_state == S_RUN) && r_done)
                r_result <= r_stage_valid ? w_acc_next : r_acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_series_accumulator.sv
`default_nettype none
// Testbench for series_accumulator: behavioural counter and ROM, randomized
// runs, and a scoreboard-driven monitor comparing against a fixed-point model.
module tb_series_accumulator;

    localparam int NT = 4;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        seq;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x_in;
    logic        start_cntr;
    logic        coeff_rd_en;
    logic [4:0]  term_cnt;
    logic [4:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic        done;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        ovf;
    logic        seq_err;

    logic [15:0] rom [0:31];
    int          idx_seq [0:NT-1];
    exp_t        sbq [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          sc_count = 0, sc_cyc = -1;
    int          done_count = 0, done_cyc = -1;
    int          rv_count = 0, rv_cyc = -1;

    series_accumulator #(
        .CNTR_DEPTH(5),
        .DATA_W(16),
        .FRAC_W(12),
        .NUM_TERMS(NT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .x_in(x_in),
        .start_cntr(start_cntr),
        .coeff_rd_en(coeff_rd_en),
        .term_cnt(term_cnt),
        .coeff_addr(coeff_addr),
        .coeff_data(coeff_data),
        .done(done),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
        .ovf(ovf),
        .seq_err(seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) coeff_data <= rom[coeff_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic longint fdiv(input longint v);
        if (v >= 0) return v / 4096;
        return -((-v + 4095) / 4096);
    endfunction

    function automatic longint clampv(input longint v, inout bit o);
        if (v > 32767) begin o = 1'b1; return 32767; end
        if (v < -32768) begin o = 1'b1; return -32768; end
        return v;
    endfunction

    // Real-number view: acc = sum c_k * x^k, each quantity floored to 2^-12
    // and clipped to the 16-bit signed range.
    function automatic exp_t model(input logic [15:0] xv);
        exp_t   r;
        longint acc, p, xs, c, pr;
        bit     o, s;
        acc = 0; p = 4096; o = 1'b0; s = 1'b0;
        xs = longint'($signed(xv));
        for (int k = 0; k < NT; k++) begin
            c   = longint'($signed(rom[idx_seq[k]]));
            if (idx_seq[k] != k) s = 1'b1;
            pr  = clampv(fdiv(c * p), o);
            acc = clampv(acc + pr, o);
            p   = clampv(fdiv(p * xs), o);
        end
        r.res = acc[15:0];
        r.ovf = o;
        r.seq = s;
        return r;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (start_cntr) begin sc_count++; sc_cyc = cyc; end
            if (done)       begin done_count++; done_cyc = cyc; end
            if (result_valid) begin
                rv_count++;
                rv_cyc = cyc;
                if (sbq.size() == 0) begin
                    chk("unexpected_result_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("seq_err", 32'(seq_err), 32'(e.seq));
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_start_cntr"}, 32'(start_cntr), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
    endtask

    task automatic run_eval(input string nm, input logic [15:0] xv, input int g_after,
                            input int g_len, input int rst_after, input bit busy_start);
        int t0, doff, sent, gap_rem, rst_phase, sc0, d0, r0;
        bit fin, done_seen, busy_pend, rv_found;
        doff = NT + 2 + ((g_after >= 0 && g_after < NT - 1) ? g_len : 0);
        sent = 0; gap_rem = 0; rst_phase = 0;
        fin = 1'b0; done_seen = 1'b0; busy_pend = 1'b0; rv_found = 1'b0;
        if (rst_after < 0) sbq.push_back(model(xv));
        @(negedge clk);
        t0 = cyc; sc0 = sc_count; d0 = done_count; r0 = rv_count;
        start = 1'b1; x_in = xv;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (busy_pend) begin start = 1'b0; busy_pend = 1'b0; end
            if (rst_phase == 2) begin
                check_zero_outputs({nm, "_after_reset"});
                rst_n = 1'b1;
                fin = 1'b1;
            end else if (rst_phase == 1) begin
                rst_n = 1'b0; coeff_rd_en = 1'b0; rst_phase = 2;
            end else if (done_seen) begin
                coeff_rd_en = 1'b0; fin = 1'b1;
            end else if (done) begin
                coeff_rd_en = 1'b1; term_cnt = 5'(NT); done_seen = 1'b1;
            end else if (sent < NT) begin
                if (gap_rem > 0) begin
                    coeff_rd_en = 1'b0; gap_rem--;
                end else begin
                    coeff_rd_en = 1'b1; term_cnt = 5'(idx_seq[sent]);
                    if (sent == g_after) gap_rem = g_len;
                    if (sent == rst_after) rst_phase = 1;
                    if (busy_start && sent == 1) begin
                        start = 1'b1; x_in = 16'h1000; busy_pend = 1'b1;
                    end
                    sent++;
                end
            end else begin
                coeff_rd_en = 1'b0;
            end
        end
        coeff_rd_en = 1'b0;
        if (!fin) chk({nm, "_timeout_done"}, 32'd0, 32'd1);
        if (rst_after >= 0) begin
            repeat (6) @(negedge clk);
            chk({nm, "_no_done_after_reset"}, 32'(done_count - d0), 32'd0);
            chk({nm, "_no_rv_after_reset"}, 32'(rv_count - r0), 32'd0);
            return;
        end
        for (int c = 0; c < 6 && !rv_found; c++) begin
            if (result_valid) begin
                rv_found = 1'b1;
                chk({nm, "_busy_at_rv"}, 32'(busy), 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        if (!rv_found) chk({nm, "_timeout_rv"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({nm, "_busy_after_rv"}, 32'(busy), 32'd0);
        chk({nm, "_start_cntr_cycle"}, 32'(sc_cyc - t0), 32'd1);
        chk({nm, "_start_cntr_count"}, 32'(sc_count - sc0), 32'd1);
        chk({nm, "_done_cycle"}, 32'(done_cyc - t0), 32'(doff));
        chk({nm, "_rv_cycle"}, 32'(rv_cyc - t0), 32'(doff + 1));
    endtask

    task automatic set_rom(input logic [15:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    task automatic set_idx_normal();
        for (int i = 0; i < NT; i++) idx_seq[i] = i;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; x_in = '0; coeff_rd_en = 1'b0; term_cnt = '0;
        set_rom(16'h1000);
        set_idx_normal();
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        run_eval("baseline", 16'h0800, -1, 0, -1, 1'b0);

        set_rom(16'h4000);
        run_eval("saturation", 16'h3000, -1, 0, -1, 1'b0);
        set_rom(16'h1000);
        run_eval("sat_recovery", 16'h0800, -1, 0, -1, 1'b0);

        idx_seq[1] = 2; idx_seq[2] = 3; idx_seq[3] = 4;
        run_eval("out_of_order", 16'h0800, -1, 0, -1, 1'b0);
        set_idx_normal();

        rom[4] = 16'h7FFF;
        run_eval("gap_overrun", 16'h0800, 1, 3, -1, 1'b0);
        rom[4] = 16'h1000;

        run_eval("reset_mid", 16'h0800, -1, 0, 2, 1'b0);
        run_eval("post_reset", 16'h0800, -1, 0, -1, 1'b0);

        run_eval("busy_start", 16'h0800, -1, 0, -1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
            run_eval("random", 16'($urandom_range(0, 16383)) - 16'd8192,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/series_accumulator.md
# series_accumulator

Consumer end of the term-counter handshake in the scientific accelerator. It launches a series evaluation by pulsing `start_cntr`, then follows the incoming `term_cnt` / `coeff_rd_en` stream. For each term it reads the coefficient ROM and accumulates `sum c_k * x^k` in signed fixed point. It returns the `done` pulse that stops the counter and presents the saturated result with a one-cycle valid strobe.

## Interface
- `CNTR_DEPTH`, 5: width of `term_cnt` / `coeff_addr`.
- `DATA_W`, 16: signed width of x, coefficients, powers and result.
- `FRAC_W`, 12: fractional bits. Format is Q(DATA_W-FRAC_W).FRAC_W.
- `NUM_TERMS`, 8: terms per evaluation. Legal range is 1..2^CNTR_DEPTH-1.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: request an evaluation. Honoured only in IDLE.
- `x_in`  in  DATA_W: operand x, sampled with an accepted `start`.
- `start_cntr`  out  1: one-cycle pulse to the term counter.
- `coeff_rd_en`  in  1: term valid from the counter.
- `term_cnt`  in  CNTR_DEPTH: term index from the counter.
- `coeff_addr`  out  CNTR_DEPTH: ROM address, combinationally equal to `term_cnt`.
- `coeff_data`  in  DATA_W: ROM data, valid 1 cycle after the address (synchronous ROM).
- `done`  out  1: one-cycle pulse to the term counter after the last term is accepted.
- `result`  out  DATA_W: accumulated sum. Held until the next accepted `start`.
- `result_valid`  out  1: one-cycle pulse.
- `busy`  out  1: high in every state except IDLE.
- `ovf`  out  1: sticky per run. Set on any saturation.
- `seq_err`  out  1: sticky per run. Set on an out-of-order term index.

## Operation
- States:
  - IDLE -> ARM on `start`.
  - ARM -> RUN unconditionally.
  - RUN -> DRAIN on `done`.
  - DRAIN -> IDLE unconditionally, pulsing `result_valid`.
- Accepted `start` (IDLE only):
  - latch x;
  - `acc`<=0, `pow`<=1.0 (1<<FRAC_W), `exp_k`<=0;
  - clear `ovf` and `seq_err`.
- `start` in any other state is ignored.
- ARM: `start_cntr`=1 for exactly this cycle.
- Term acceptance condition: RUN && `coeff_rd_en` && `exp_k` < NUM_TERMS. On each accepted term:
  - `exp_k`++;
  - a 1-deep valid flag is set for the next cycle;
  - if `term_cnt` != `exp_k`, set `seq_err`. The term is still processed.
- Terms arriving outside RUN, or with `exp_k` == NUM_TERMS, are ignored. This covers the counter's overrun index NUM_TERMS in the cycle `done` is seen.
- `done` is a registered pulse, asserted the cycle after the term with `exp_k` == NUM_TERMS-1 is accepted.
- Multiply-accumulate stage (cycle after acceptance, using `coeff_data`):
  - `prod` = (`coeff_data` * `pow`) >>> FRAC_W, computed at full 2*DATA_W width with arithmetic shift (truncate toward -inf), then saturated to DATA_W;
  - `acc` <= sat(`acc` + `prod`);
  - `pow` <= sat((`pow` * x) >>> FRAC_W).
  - `pow` is updated only on stage-valid cycles, so the term with `exp_k` == k always uses x^k.
- Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp of `prod`, `acc` or `pow` sets `ovf`.
- DRAIN: `result` <= `acc`, `result_valid`=1. The last MAC completes at the end of the `done` cycle, so `acc` is final here.

## Timing
- Reset (`rst_n`=0 at a clock edge): state IDLE.
  - `start_cntr`, `done`, `result_valid`, `busy`, `ovf`, `seq_err` = 0;
  - `result`, `acc` = 0; `pow` = 1.0; `exp_k` = 0.
  - Reset mid-run aborts the run with no `done` and no `result_valid`.
- Nominal run (gap-free counter): `start` accepted at T0.
  - `start_cntr` at T0+1.
  - Terms 0..N-1 accepted at T0+2..T0+N+1.
  - `done` at T0+N+2.
  - `result_valid` at T0+N+3.
  - `busy` is high from T0+1 through T0+N+3 inclusive.
- `coeff_rd_en` gaps during RUN stall acceptance. Latency grows by the gap length. Output ordering is unchanged.
- `done` and the acceptance of an overrun index in the same cycle: the overrun term is ignored.
- A back-to-back `start` is first accepted in the cycle after `result_valid` (state IDLE).

## Test plan
- Baseline:
  - Stimulus: DATA_W=16, FRAC_W=12, N=4, x=0x0800 (0.5), all coeffs 0x1000 (1.0), behavioural counter.
  - Required: `start_cntr` at T0+1, `done` at T0+6, `result`=0x1E00 (1.875) with `result_valid` at T0+7, `ovf`=0, `seq_err`=0.
- Saturation:
  - Stimulus: x=0x3000 (3.0), coeffs 0x4000, N=4.
  - Required: `result`=0x7FFF, `ovf`=1. A following run with x=0x0800 and coeffs 0x1000 clears `ovf` and returns 0x1E00.
- Out-of-order indices:
  - Stimulus: counter drives indices 0,2,3,4 with N=4.
  - Required: `seq_err`=1, `done` still after the 4th accepted term, `result_valid` one cycle later.
- Gap plus overrun:
  - Stimulus: deassert `coeff_rd_en` for 3 cycles after term 1. Drive index 4 with `coeff_data`=0x7FFF in the `done` cycle.
  - Required: result unchanged from baseline (0x1E00), `result_valid` at T0+10.
- Reset mid-run:
  - Stimulus: drop `rst_n` for one cycle after term 2.
  - Required: all outputs 0 next cycle, no `done`, no `result_valid`. A new run then matches baseline.
- Busy `start`:
  - Stimulus: pulse `start` with x=0x1000 during RUN.
  - Required: ignored. Result equals the original run's value and no second `start_cntr` is issued.
